// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the two-port memory arbiter.
// Build option: define MEM_ARB_RR_EN for round-robin conflict resolution.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_MEM_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Winner selection between fetch (I) and data (D) requests.
// grant[0] = fetch port, grant[1] = data port; at most one bit set.
// Build option: MEM_ARB_RR_EN alternates on conflicts, otherwise D always wins.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic       i_valid,
  input  logic       d_valid,
  input  port_e      last_grant,
  output logic [1:0] grant
);

`ifndef MEM_ARB_RR_EN
  // Fixed priority ignores grant history.
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == PORT_D);
`endif

  // Pick a single winner from the current valids.
  always_comb begin
    grant = 2'b00;
    if (i_valid && d_valid) begin
`ifdef MEM_ARB_RR_EN
      grant = (last_grant == PORT_D) ? 2'b01 : 2'b10;
`else
      grant = 2'b10;
`endif
    end else if (d_valid) begin
      grant = 2'b10;
    end else if (i_valid) begin
      grant = 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single fixed-latency memory.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Build option: MEM_ARB_RR_EN enables the round-robin conflict policy.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rsp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_be,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  port_e               owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-3:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  port_e               last_grant;
  logic [1:0]          grant;
  logic                idle;

  // Byte offset within the word never reaches the memory.
  logic unused_addr_lo;
  assign unused_addr_lo = ^{i_req_addr[1:0], d_req_addr[1:0]};

`ifdef MEM_ARB_RR_EN
  port_e last_q, last_d;

  // Remember which port won the most recent accept.
  always_ff @(posedge clk) begin
    if (rst) last_q <= PORT_I;
    else     last_q <= last_d;
  end

  // Update grant history only on an accept.
  always_comb begin
    last_d = last_q;
    if (idle && grant[1])      last_d = PORT_D;
    else if (idle && grant[0]) last_d = PORT_I;
  end

  assign last_grant = last_q;
`else
  assign last_grant = PORT_I;
`endif

  mem_arb_grant u_grant (
    .i_valid    (i_req_valid),
    .d_valid    (d_req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign idle = (state_q == ST_IDLE);

  // Next-state and request latching.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (grant[1]) begin
          owner_d = PORT_D;
          we_d    = d_req_we;
          addr_d  = d_req_addr[ADDR_W-1:2];
          wdata_d = d_req_wdata;
          be_d    = d_req_be;
          state_d = ST_ISSUE;
        end else if (grant[0]) begin
          owner_d = PORT_I;
          we_d    = 1'b0;
          addr_d  = i_req_addr[ADDR_W-1:2];
          wdata_d = '0;
          be_d    = '1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = LAT4;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d      = 4'd0;
          rsp_data_d = we_q ? '0 : mem_rdata;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-request registers; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      owner_q    <= PORT_I;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Ready is held low during reset so nothing is accepted and then lost.
  assign i_req_ready = idle && grant[0] && !rst;
  assign d_req_ready = idle && grant[1] && !rst;

  assign i_rsp_valid = (state_q == ST_RESP) && (owner_q == PORT_I);
  assign d_rsp_valid = (state_q == ST_RESP) && (owner_q == PORT_D);
  assign i_rsp_data  = rsp_data_q;
  assign d_rsp_data  = rsp_data_q;

  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one MEM_LAT=1 instance with a byte-enable
// memory model and one MEM_LAT=4 instance for latency checks.
// Expected grant order follows MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- MEM_LAT = 1 instance ----------------
  logic        i_req_valid, i_req_ready, i_rsp_valid;
  logic [31:0] i_req_addr, i_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [3:0]  d_req_be;
  logic        mem_en, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // Memory model: read data is valid only exactly MEM_LAT cycles after mem_en.
  logic [31:0] mem1 [0:63];
  logic [31:0] rd1;
  int          lat1;
  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < 64; w++) mem1[w] <= 32'h0;
      mem1[4]  <= 32'h1234_5678;
      mem1[12] <= 32'h5555_AAAA;
      lat1 <= 0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem1[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        rd1 <= mem1[mem_addr[5:0]];
      end
      lat1 <= 1;
    end else if (lat1 != 0) begin
      lat1 <= lat1 - 1;
    end
  end
  assign mem_rdata = (lat1 == 1) ? rd1 : 32'hBAD0_BAD0;

  // ---------------- MEM_LAT = 4 instance ----------------
  logic        f4_i_valid, f4_i_ready, f4_i_rsp_valid, f4_d_ready, f4_d_rsp_valid;
  logic [31:0] f4_i_addr, f4_i_rsp_data, f4_unused_d_rsp_data, f4_unused_wdata, f4_rdata;
  logic        f4_mem_en, f4_mem_we;
  logic [29:0] f4_mem_addr;
  logic [3:0]  f4_mem_be;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) dut4 (
    .clk(clk), .rst(rst),
    .i_req_valid(f4_i_valid), .i_req_ready(f4_i_ready), .i_req_addr(f4_i_addr),
    .i_rsp_valid(f4_i_rsp_valid), .i_rsp_data(f4_i_rsp_data),
    .d_req_valid(1'b0), .d_req_ready(f4_d_ready), .d_req_addr(32'h0),
    .d_req_we(1'b0), .d_req_wdata(32'h0), .d_req_be(4'h0),
    .d_rsp_valid(f4_d_rsp_valid), .d_rsp_data(f4_unused_d_rsp_data),
    .mem_en(f4_mem_en), .mem_we(f4_mem_we), .mem_addr(f4_mem_addr),
    .mem_wdata(f4_unused_wdata), .mem_be(f4_mem_be), .mem_rdata(f4_rdata)
  );

  logic [31:0] rd4;
  int          lat4;
  always @(posedge clk) begin
    if (rst) begin
      lat4 <= 0;
    end else if (f4_mem_en) begin
      rd4  <= (f4_mem_addr == 30'd2) ? 32'hCAFE_F00D : 32'h0;
      lat4 <= 4;
    end else if (lat4 != 0) begin
      lat4 <= lat4 - 1;
    end
  end
  assign f4_rdata = (lat4 == 1) ? rd4 : 32'hBAD0_BAD0;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One data-port transaction on the MEM_LAT=1 instance, response expected at T+3.
  task automatic d_txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_data);
    int n;
    d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr;
    d_req_wdata = wdata; d_req_be = be;
    #1;
    check({tag, "_ready"}, 64'(d_req_ready), 64'd1);
    tick();
    d_req_valid = 1'b0;
    check({tag, "_mem_en"}, 64'(mem_en), 64'd1);
    check({tag, "_mem_we"}, 64'(mem_we), 64'(we));
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'(addr[31:2]));
    n = 0;
    while (!d_rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd2);
    check({tag, "_data"}, 64'(d_rsp_data), 64'(exp_data));
    check({tag, "_i_rsp"}, 64'(i_rsp_valid), 64'd0);
    $display("[TB] txn %s: D we=%0d addr=0x%08h data=0x%08h", tag, we, addr, d_rsp_data);
    tick();
    check({tag, "_rsp_pulse"}, 64'(d_rsp_valid), 64'd0);
  endtask

  int exp_g [3];
  int got_g [3];
  int g_cyc [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int t0;
`ifdef MEM_ARB_RR_EN
    exp_g = '{1, 0, 1};
`else
    exp_g = '{1, 1, 1};
`endif
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_addr = 32'h0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = 32'h0;
    d_req_wdata = 32'h0; d_req_be = 4'h0;
    f4_i_valid = 1'b0; f4_i_addr = 32'h0;
    repeat (3) tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_i_ready", 64'(i_req_ready), 64'd0);
    check("rst_d_ready", 64'(d_req_ready), 64'd0);
    check("rst_rsp_valid", 64'({i_rsp_valid, d_rsp_valid}), 64'd0);
    check("rst_mem_en_we", 64'({mem_en, mem_we}), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_be", 64'(mem_be), 64'd0);
    check("rst_rsp_data", 64'({i_rsp_data, d_rsp_data}), 64'd0);
    $display("[TB] txn reset: state checked");

    // Single fetch of 0x10
    tick();
    i_req_valid = 1'b1; i_req_addr = 32'h0000_0010;
    #1;
    check("f1_ready", 64'(i_req_ready), 64'd1);
    check("f1_d_ready", 64'(d_req_ready), 64'd0);
    tick();
    i_req_valid = 1'b0;
    check("f1_mem_en", 64'(mem_en), 64'd1);
    check("f1_mem_addr", 64'(mem_addr), 64'h4);
    check("f1_mem_we", 64'(mem_we), 64'd0);
    check("f1_mem_be", 64'(mem_be), 64'hF);
    check("f1_busy_ready", 64'(i_req_ready), 64'd0);
    tick();
    check("f1_mem_en_once", 64'(mem_en), 64'd0);
    check("f1_rsp_early", 64'(i_rsp_valid), 64'd0);
    tick();
    check("f1_rsp_valid", 64'(i_rsp_valid), 64'd1);
    check("f1_rsp_data", 64'(i_rsp_data), 64'h1234_5678);
    check("f1_d_rsp", 64'(d_rsp_valid), 64'd0);
    $display("[TB] txn fetch: addr=0x00000010 data=0x%08h", i_rsp_data);
    tick();
    check("f1_rsp_pulse", 64'(i_rsp_valid), 64'd0);

    // Store then load, plus partial byte enables and ignored low address bits
    d_txn("st", 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, 32'h0);
    d_txn("ld", 1'b0, 32'h20, 32'h0, 4'hF, 32'hDEAD_BEEF);
    d_txn("ld_lo", 1'b0, 32'h23, 32'h0, 4'hF, 32'hDEAD_BEEF);
    d_txn("st_be", 1'b1, 32'h24, 32'hAABB_CCDD, 4'h5, 32'h0);
    d_txn("ld_be", 1'b0, 32'h24, 32'h0, 4'hF, 32'h00BB_00DD);

    // Conflict: both valids held across three accepts, from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h30;
    #1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!(i_req_ready || d_req_ready) && n < 20) begin
        tick();
        n++;
      end
      got_g[k] = d_req_ready ? 1 : (i_req_ready ? 0 : 2);
      g_cyc[k] = cyc;
      check($sformatf("cf_onehot%0d", k), 64'(i_req_ready & d_req_ready), 64'd0);
      check($sformatf("cf_grant%0d", k), 64'(got_g[k]), 64'(exp_g[k]));
      $display("[TB] txn conflict %0d: grant=%s", k, (got_g[k] == 1) ? "D" : "I");
      tick();
      if (k == 2) begin
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
      end
    end
    check("cf_space01", 64'(g_cyc[1] - g_cyc[0]), 64'd4);
    check("cf_space12", 64'(g_cyc[2] - g_cyc[1]), 64'd4);
    repeat (4) tick();

    // Reset while waiting on memory, with a data request pending
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    #1;
    check("rw_ready", 64'(i_req_ready), 64'd1);
    tick();
    i_req_valid = 1'b0;
    tick();
    rst = 1'b1;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h30;
    #1;
    check("rw_ready_in_rst", 64'(d_req_ready), 64'd0);
    tick();
    check("rw_no_rsp", 64'({i_rsp_valid, d_rsp_valid}), 64'd0);
    check("rw_mem_en", 64'(mem_en), 64'd0);
    rst = 1'b0;
    #1;
    check("rw_idle_accept", 64'(d_req_ready), 64'd1);
    tick();
    d_req_valid = 1'b0;
    check("rw_no_rsp2", 64'(i_rsp_valid), 64'd0);
    check("rw_mem_addr", 64'(mem_addr), 64'hC);
    tick();
    check("rw_no_rsp3", 64'({i_rsp_valid, d_rsp_valid}), 64'd0);
    tick();
    check("rw_d_rsp", 64'(d_rsp_valid), 64'd1);
    check("rw_d_data", 64'(d_rsp_data), 64'h5555_AAAA);
    check("rw_i_rsp", 64'(i_rsp_valid), 64'd0);
    $display("[TB] txn reset-in-wait: pending load data=0x%08h", d_rsp_data);
    tick();

    // MEM_LAT = 4 fetch: response at T+6, ready low T+1..T+6
    f4_i_valid = 1'b1; f4_i_addr = 32'h8;
    #1;
    check("l4_ready", 64'(f4_i_ready), 64'd1);
    tick();
    f4_i_valid = 1'b0;
    check("l4_mem_en", 64'(f4_mem_en), 64'd1);
    check("l4_mem_we_be", 64'({f4_mem_we, f4_mem_be}), 64'hF);
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("l4_busy%0d", k), 64'(f4_i_ready), 64'd0);
      check($sformatf("l4_rsp%0d", k), 64'(f4_i_rsp_valid), 64'(k == 6));
      check($sformatf("l4_d_rsp%0d", k), 64'({f4_d_ready, f4_d_rsp_valid}), 64'd0);
      if (k == 6) begin
        check("l4_data", 64'(f4_i_rsp_data), 64'hCAFE_F00D);
        $display("[TB] txn lat4 fetch: addr=0x00000008 data=0x%08h", f4_i_rsp_data);
      end else begin
        tick();
      end
    end
    tick();
    check("l4_rsp_pulse", 64'(f4_i_rsp_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
